// File: rtl/sram_port_arbiter_if.sv
// Requester, response and SRAM command signals shared by sram_port_arbiter and its environment.
interface sram_port_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int MW   = DW / 8,
  parameter int AW   = 14
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*MW-1:0] req_wem;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               sram_cs;
  logic               sram_we;
  logic [MW-1:0]      sram_wem;
  logic [AW-1:0]      sram_addr;
  logic [DW-1:0]      sram_din;
  logic [DW-1:0]      sram_dout;
  logic               busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wem, sram_dout,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_cs, sram_we, sram_wem, sram_addr, sram_din, busy
  );

  // Requesters plus the SRAM macro, seen as one environment.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wem, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_cs, sram_we, sram_wem, sram_addr, sram_din, busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with bounded burst locking that shares one single-port SRAM
// between NREQ requesters; registered SRAM command, tagged two-cycle read return.
module sram_port_arbiter #(
  parameter int NREQ      = 3,
  parameter int DW        = 32,
  parameter int MW        = DW / 8,
  parameter int AW        = 14,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave bus
);
  localparam int         IW         = $clog2(NREQ);
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [3:0]      burst_q, burst_d;
  logic            sram_cs_q, sram_cs_d;
  logic            sram_we_q, sram_we_d;
  logic [MW-1:0]   sram_wem_q, sram_wem_d;
  logic [AW-1:0]   sram_addr_q, sram_addr_d;
  logic [DW-1:0]   sram_din_q, sram_din_d;
  logic [NREQ-1:0] rd_tag_q, rd_tag_d;

  logic            others_valid;
  logic            lock;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] ready;

  // sram_cs_q doubles as "previous cycle was a transfer by owner", since every
  // transfer also moves ownership to the granted requester.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    others_valid = |(bus.req_valid & ~(NREQ'(1) << owner_q));
    lock         = bus.req_valid[owner_q] && sram_cs_q &&
                   ((burst_q < BURST_LAST) || !others_valid);
    grant_vld    = lock;
    grant_idx    = owner_q;
    cand         = '0;
    if (!lock) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IW'((int'(last_grant_q) + k) % NREQ);
        if (!grant_vld && bus.req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    ready = grant_vld ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    burst_d      = '0;
    if (lock) burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 4'd1;
    last_grant_d = grant_vld ? grant_idx : last_grant_q;
    owner_d      = grant_vld ? grant_idx : owner_q;
    sram_cs_d    = grant_vld;
    sram_we_d    = grant_vld & bus.req_we[grant_idx];
    sram_addr_d  = grant_vld ? bus.req_addr[grant_idx*AW +: AW]  : sram_addr_q;
    sram_din_d   = grant_vld ? bus.req_wdata[grant_idx*DW +: DW] : sram_din_q;
    sram_wem_d   = grant_vld ? bus.req_wem[grant_idx*MW +: MW]   : sram_wem_q;
    // The command stage's requester is still owner_q when its read reaches the SRAM.
    rd_tag_d     = (sram_cs_q && !sram_we_q) ? (NREQ'(1) << owner_q) : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IW'(NREQ - 1);
      owner_q      <= '0;
      burst_q      <= '0;
      sram_cs_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_wem_q   <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      rd_tag_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      sram_cs_q    <= sram_cs_d;
      sram_we_q    <= sram_we_d;
      sram_wem_q   <= sram_wem_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rd_tag_q;
  assign bus.rsp_rdata = bus.sram_dout;
  assign bus.sram_cs   = sram_cs_q;
  assign bus.sram_we   = sram_we_q;
  assign bus.sram_wem  = sram_wem_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_din  = sram_din_q;
  assign bus.busy      = sram_cs_q | (|rd_tag_q);
endmodule
